sign_reduction: RTL and testbench

SIGN_REDUCTION -- requirements
Module: sign_reduction

---
 rtl/sign_reduction.sv | 97 +++++++++
 tb/tb_sign_reduction.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sign_reduction.sv
// rtl/sign_reduction.sv - registered narrowing of a signed word with overflow flag and count (SIGN_SAT_EN selects saturation)
module sign_reduction #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_sign,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic [7:0]       ovf_cnt,
  input  logic             clr_cnt
);

  logic [OUT_W-1:0] out_sign_q, out_sign_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  ovf;
  logic [IN_W-OUT_W:0]   top_bits;
  logic [OUT_W-1:0]      reduced;

`ifdef SIGN_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

  // The register frees up when empty or when its word leaves this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // The word fits only if everything from the new sign bit upward is a copy of the sign.
  assign top_bits = in_sign[IN_W-1:OUT_W-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  // Pick the narrowed value: clamp to the extreme on overflow, or plain truncation.
  always_comb begin
    reduced = in_sign[OUT_W-1:0];
`ifdef SIGN_SAT_EN
    if (ovf) begin
      reduced = in_sign[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  // Output holding register and saturating overflow counter next state.
  always_comb begin
    out_sign_d  = out_sign_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    ovf_cnt_d   = ovf_cnt_q;

    if (in_xfer) begin
      out_sign_d  = reduced;
      out_ovf_d   = ovf;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    // A clear that coincides with a counted word leaves that one word counted.
    if (clr_cnt) begin
      ovf_cnt_d = (in_xfer && ovf) ? 8'd1 : 8'd0;
    end else if (in_xfer && ovf && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // State register; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_cnt_q   <= 8'd0;
    end else begin
      out_sign_q  <= out_sign_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign out_sign  = out_sign_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_sign_reduction.sv
// tb/tb_sign_reduction.sv - directed self-checking bench for sign_reduction
module tb_sign_reduction;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_sign;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_sign;
  logic       out_valid;
  logic       out_ready;
  logic       out_ovf;
  logic [7:0] ovf_cnt;
  logic       clr_cnt;

  int checks;
  int errors;

`ifdef SIGN_SAT_EN
  localparam logic [2:0] EXP_05 = 3'b011;
  localparam logic [2:0] EXP_80 = 3'b100;
  localparam logic [2:0] EXP_40 = 3'b011;
`else
  localparam logic [2:0] EXP_05 = 3'b101;
  localparam logic [2:0] EXP_80 = 3'b000;
  localparam logic [2:0] EXP_40 = 3'b000;
`endif

  sign_reduction #(.IN_W(8), .OUT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sign   (in_sign),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sign  (out_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt),
    .clr_cnt   (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_sign   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;

    #12;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_sign", out_sign, 0);
    check_val("rst_ovf", out_ovf, 0);
    check_val("rst_cnt", ovf_cnt, 0);
    check_val("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // basic in-range and overflow words, one per cycle
    in_valid = 1'b1; in_sign = 8'h03; step();
    check_val("v03_valid", out_valid, 1);
    check_val("v03_sign", out_sign, 3'b011);
    check_val("v03_ovf", out_ovf, 0);
    check_val("v03_cnt", ovf_cnt, 0);
    in_sign = 8'hFC; step();
    check_val("vFC_sign", out_sign, 3'b100);
    check_val("vFC_ovf", out_ovf, 0);
    in_sign = 8'hFF; step();
    check_val("vFF_sign", out_sign, 3'b111);
    check_val("vFF_ovf", out_ovf, 0);
    in_sign = 8'h05; step();
    check_val("v05_sign", out_sign, EXP_05);
    check_val("v05_ovf", out_ovf, 1);
    check_val("v05_cnt", ovf_cnt, 1);
    in_sign = 8'h80; step();
    check_val("v80_sign", out_sign, EXP_80);
    check_val("v80_ovf", out_ovf, 1);
    check_val("v80_cnt", ovf_cnt, 2);

    // drain with an overflowing word present but not valid
    in_valid = 1'b0; in_sign = 8'h80; step();
    check_val("drain_valid", out_valid, 0);
    check_val("ignored_cnt", ovf_cnt, 2);

    // backpressure: 02 held, pending 40 must not be accepted
    in_valid = 1'b1; in_sign = 8'h02; step();
    check_val("bp_load", out_sign, 3'b010);
    out_ready = 1'b0; in_sign = 8'h40; #1;
    check_val("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_sign", out_sign, 3'b010);
      check_val("bp_valid", out_valid, 1);
      check_val("bp_ovf", out_ovf, 0);
    end
    check_val("bp_cnt", ovf_cnt, 2);
    out_ready = 1'b1; #1;
    check_val("rel_in_ready", in_ready, 1);
    step();
    check_val("rel_w0_sign", out_sign, EXP_40);
    check_val("rel_w0_cnt", ovf_cnt, 3);
    in_sign = 8'h01; step();
    check_val("rel_w1_sign", out_sign, 3'b001);
    check_val("rel_w1_valid", out_valid, 1);

    // counter saturation, then clear coinciding with an overflowing accept
    in_sign = 8'h40;
    for (int i = 0; i < 300; i++) step();
    check_val("sat_cnt", ovf_cnt, 255);
    clr_cnt = 1'b1; step();
    check_val("clr_ovf_cnt", ovf_cnt, 1);
    in_valid = 1'b0; step();
    check_val("clr_only_cnt", ovf_cnt, 0);
    clr_cnt = 1'b0;

    // asynchronous reset with a word held
    in_valid = 1'b1; in_sign = 8'h05; step();
    check_val("pre_rst_valid", out_valid, 1);
    check_val("pre_rst_cnt", ovf_cnt, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", out_valid, 0);
    check_val("arst_sign", out_sign, 0);
    check_val("arst_ovf", out_ovf, 0);
    check_val("arst_cnt", ovf_cnt, 0);
    check_val("arst_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_sign = 8'hFF; out_ready = 1'b1; step();
    check_val("post_rst_valid", out_valid, 1);
    check_val("post_rst_sign", out_sign, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
